// File: rtl/rtc_event_capture_pkg.sv
// Shared definitions for the RTC event timestamp capture block:
// register map, CTRL/STATUS bit positions and the FIFO entry layout.
package rtc_event_capture_pkg;

    localparam int TS_W = 32;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_TS      = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_HOLDOFF = 2'd3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_PIEZO  = 2;
    localparam int CTRL_FLUSH  = 31;

    localparam int ST_LEVEL_LSB = 0;
    localparam int ST_LEVEL_W   = 9;
    localparam int ST_EMPTY     = 9;
    localparam int ST_FULL      = 10;
    localparam int ST_OVERFLOW  = 11;
    localparam int ST_HEAD_SRC  = 12;

    typedef struct packed {
        logic            src;
        logic [TS_W-1:0] ts;
    } ts_entry_t;

endpackage

// File: rtl/rtc_event_capture_sync.sv
// Per-channel trigger front end: metastability synchroniser, rising-edge
// detect and re-trigger holdoff down-counter.
module event_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trig_in,
    input  logic                 enable,
    input  logic                 pend_busy,
    input  logic [HOLDOFF_W-1:0] holdoff_val,
    output logic                 accept,
    output logic                 drop
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [HOLDOFF_W-1:0]   hold_q, hold_d;
    logic                   edge_det;
    logic                   armed;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], trig_in};
        prev_d   = sync_q[SYNC_STAGES-1];
        edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
        armed    = edge_det & enable & (hold_q == '0);
        accept   = armed & ~pend_busy;
        drop     = armed & pend_busy;

        // Only an accepted capture restarts the holdoff window.
        hold_d = hold_q;
        if (accept) begin
            hold_d = holdoff_val;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLDOFF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            hold_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/rtc_event_capture.sv
// Timestamps edges on two asynchronous event inputs against the RTC count
// and queues them in a FIFO read by the host over Avalon-MM.
module rtc_event_capture #(
    parameter int TIME_W      = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TIME_W-1:0] time_in,
    input  logic              event_trigger,
    input  logic              event_trigger2,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    output logic              piezo_enable
);
    import rtc_event_capture_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    ts_entry_t            mem_q [FIFO_DEPTH];
    ts_entry_t            mem_d [FIFO_DEPTH];
    logic [AW:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic                 overflow_q, overflow_d;
    logic [2:0]           ctrl_q, ctrl_d;
    logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
    logic [1:0]           pend_vld_q, pend_vld_d;
    logic [TIME_W-1:0]    pend_ts_q [2];
    logic [TIME_W-1:0]    pend_ts_d [2];
    logic [31:0]          rdata_q, rdata_d;
    logic                 irq_q, irq_d;
    logic                 piezo_q, piezo_d;

    logic [1:0]  accept, drop, drain, pend_busy;
    logic [AW:0] level;
    logic        empty, full, push_req, push_ok, pop, flush, ctrl_wr, hold_wr;
    ts_entry_t   push_entry, head;
    logic        unused_wdata;

    assign unused_wdata = ^avs_writedata;

    // Channel 0 always drains its pending slot; channel 1 waits a cycle on contention.
    always_comb begin
        drain[0]  = pend_vld_q[0];
        drain[1]  = pend_vld_q[1] & ~pend_vld_q[0];
        pend_busy = pend_vld_q & ~drain;
    end

    event_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .HOLDOFF_W(HOLDOFF_W)) u_sync0 (
        .clk         (clk),
        .rst         (reset),
        .trig_in     (event_trigger),
        .enable      (ctrl_q[CTRL_ENABLE]),
        .pend_busy   (pend_busy[0]),
        .holdoff_val (holdoff_q),
        .accept      (accept[0]),
        .drop        (drop[0])
    );

    event_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .HOLDOFF_W(HOLDOFF_W)) u_sync1 (
        .clk         (clk),
        .rst         (reset),
        .trig_in     (event_trigger2),
        .enable      (ctrl_q[CTRL_ENABLE]),
        .pend_busy   (pend_busy[1]),
        .holdoff_val (holdoff_q),
        .accept      (accept[1]),
        .drop        (drop[1])
    );

    always_comb begin
        level         = wptr_q - rptr_q;
        empty         = (level == '0);
        full          = (level == DEPTH_C);
        head          = mem_q[rptr_q[AW-1:0]];
        push_req      = |pend_vld_q;
        push_entry.src = ~pend_vld_q[0];
        push_entry.ts  = pend_vld_q[0] ? TS_W'(pend_ts_q[0]) : TS_W'(pend_ts_q[1]);
        pop           = avs_read & (avs_address == ADDR_TS) & ~empty;
        push_ok       = push_req & (~full | pop);
        ctrl_wr       = avs_write & (avs_address == ADDR_CTRL);
        hold_wr       = avs_write & (avs_address == ADDR_HOLDOFF);
        flush         = ctrl_wr & avs_writedata[CTRL_FLUSH];
    end

    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        ctrl_d     = ctrl_q;
        holdoff_d  = holdoff_q;
        pend_vld_d = pend_vld_q;
        pend_ts_d  = pend_ts_q;

        if (push_ok) begin
            mem_d[wptr_q[AW-1:0]] = push_entry;
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
        if ((push_req & full & ~pop) | (|drop)) begin
            overflow_d = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
                pend_vld_d[i] = 1'b1;
                pend_ts_d[i]  = time_in;
            end else if (drain[i]) begin
                pend_vld_d[i] = 1'b0;
            end
        end
        if (ctrl_wr) begin
            ctrl_d = avs_writedata[2:0];
        end
        if (hold_wr) begin
            holdoff_d = avs_writedata[HOLDOFF_W-1:0];
        end
        // Flush overrides any same-cycle push, pop or capture.
        if (flush) begin
            wptr_d     = '0;
            rptr_d     = '0;
            overflow_d = 1'b0;
            pend_vld_d = '0;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (avs_read) begin
            case (avs_address)
                ADDR_STATUS: begin
                    rdata_d[ST_LEVEL_LSB +: ST_LEVEL_W] = ST_LEVEL_W'(level);
                    rdata_d[ST_EMPTY]    = empty;
                    rdata_d[ST_FULL]     = full;
                    rdata_d[ST_OVERFLOW] = overflow_q;
                    rdata_d[ST_HEAD_SRC] = ~empty & head.src;
                end
                ADDR_TS: begin
                    if (!empty) begin
                        rdata_d = 32'(head.ts);
                    end
                end
                ADDR_CTRL:    rdata_d[2:0] = ctrl_q;
                ADDR_HOLDOFF: rdata_d[HOLDOFF_W-1:0] = holdoff_q;
                default:      rdata_d = '0;
            endcase
        end
        irq_d   = ctrl_q[CTRL_IRQ_EN] & (~empty | overflow_q);
        piezo_d = ctrl_q[CTRL_PIEZO];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            ctrl_q     <= '0;
            holdoff_q  <= '0;
            pend_vld_q <= '0;
            pend_ts_q[0] <= '0;
            pend_ts_q[1] <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            piezo_q    <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            ctrl_q     <= ctrl_d;
            holdoff_q  <= holdoff_d;
            pend_vld_q <= pend_vld_d;
            pend_ts_q  <= pend_ts_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            piezo_q    <= piezo_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign piezo_enable = piezo_q;

endmodule
